pc_gen: RTL and testbench

- Fetch-side program counter unit for the single-cycle MIPS core. It owns the PC register and computes the next PC for sequential, branch, j/jal and jr/jalr flow.
- Adds a parametrised return-address stack (RAS) so `jr $ra`-style returns are served from hardware. The registered-PC variant adds stall support.
- Sits between the controller (npc_op, branch decision) and IM/GRF (pc, link_addr).

---
 rtl/pc_gen.sv | 124 ++++++++++++
 tb/tb_pc_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-side PC unit: PC register, next-PC select, return-address stack with stall.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          RAS_DEPTH = 4,
  parameter int          RAS_PTR_W = 2,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic        branch_taken,
  input  logic [25:0] imm,
  input  logic [31:0] ra,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] link_addr,
  output logic        ras_empty,
  output logic        ras_full,
  output logic        ras_miss
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        pc_misalign
`endif
);

  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_J      = 3'd2;
  localparam logic [2:0] OP_JAL    = 3'd3;
  localparam logic [2:0] OP_JR     = 3'd4;
  localparam logic [2:0] OP_JALR   = 3'd5;
  localparam logic [2:0] OP_RET    = 3'd6;
  localparam logic [RAS_PTR_W:0] DEPTH_C = (RAS_PTR_W+1)'(RAS_DEPTH);

  logic [31:0]          pc_q, pc_d;
  logic [RAS_PTR_W-1:0] ptr_q, ptr_d, top_idx;
  logic [RAS_PTR_W:0]   cnt_q, cnt_d;
  logic                 miss_q, miss_d;
  logic [31:0]          ras_q [RAS_DEPTH];

  logic [31:0]        pc_4, tgt, ras_top;
  logic signed [31:0] boff;
  logic               push, pop;

  assign pc_4      = pc_q + 32'd4;
  assign boff      = $signed({{14{imm[15]}}, imm[15:0], 2'b00});
  assign top_idx   = ptr_q - 1'b1;
  assign ras_top   = ras_q[top_idx];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == DEPTH_C);

  assign pc        = pc_q;
  assign link_addr = pc_4;
  assign ras_miss  = miss_q;

  // Raw target selection; npc may be redirected by the alignment check below.
  always_comb begin
    tgt = pc_4;
    case (npc_op)
      OP_BRANCH:      if (branch_taken) tgt = pc_4 + $unsigned(boff);
      OP_J, OP_JAL:   tgt = {pc_q[31:28], imm, 2'b00};
      OP_JR, OP_JALR: tgt = ra;
      OP_RET:         tgt = ras_empty ? ra : ras_top;
      default:        tgt = pc_4;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign, mis_q, mis_d;
  assign misalign    = (tgt[1:0] != 2'b00);
  assign npc         = misalign ? EXC_VEC : tgt;
  assign mis_d       = stall ? mis_q : misalign;
  assign pc_misalign = mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`else
  assign npc = tgt;
`endif

  // RAS bookkeeping: push/pop still happen when the target is redirected.
  always_comb begin
    push   = !stall && (npc_op == OP_JAL || npc_op == OP_JALR);
    pop    = !stall && (npc_op == OP_RET) && !ras_empty;
    pc_d   = stall ? pc_q : npc;
    miss_d = stall ? miss_q : ((npc_op == OP_RET) && ras_empty);
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      ptr_d = ptr_q + 1'b1;
      if (!ras_full) cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      ptr_q  <= '0;
      cnt_q  <= '0;
      miss_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
    end
  end

  // Circular storage: a push when full silently overwrites the oldest entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (push) begin
      ras_q[ptr_q] <= pc_4;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential flow, branches, jumps, RAS push/pop/overflow/miss, stall, reset.
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  npc_op;
  logic        branch_taken;
  logic [25:0] imm;
  logic [31:0] ra;
  logic [31:0] pc, npc, link_addr;
  logic        ras_empty, ras_full, ras_miss;
`ifdef PC_ALIGN_CHECK_EN
  logic        pc_misalign;
`endif

  int errors = 0;
  int checks = 0;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op),
    .branch_taken(branch_taken), .imm(imm), .ra(ra),
    .pc(pc), .npc(npc), .link_addr(link_addr),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_miss(ras_miss)
`ifdef PC_ALIGN_CHECK_EN
    , .pc_misalign(pc_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [25:0] im, input logic tk,
                       input logic [31:0] r, input logic st);
    npc_op = op; imm = im; branch_taken = tk; ra = r; stall = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(3'd0, 26'd0, 1'b0, 32'd0, 1'b0);
    #12;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_full", 32'(ras_full), 32'd0);
    chk("rst_miss", 32'(ras_miss), 32'd0);
    chk("rst_npc", npc, 32'h3004);
    chk("rst_link", link_addr, 32'h3004);
    @(negedge clk);
    reset = 1'b1;

    step(); chk("seq1", pc, 32'h3004);
    step(); chk("seq2", pc, 32'h3008);
    step(); chk("seq3", pc, 32'h300C);
    chk("seq_empty", 32'(ras_empty), 32'd1);

    // Branch taken backward from 0x3010
    drive(3'd2, 26'h0000C04, 1'b0, 32'd0, 1'b0); step(); chk("j_3010a", pc, 32'h3010);
    drive(3'd1, 26'h000FFFC, 1'b1, 32'd0, 1'b0);
    #1 chk("br_t_npc", npc, 32'h3004);
    step(); chk("br_t_pc", pc, 32'h3004);
    drive(3'd2, 26'h0000C04, 1'b0, 32'd0, 1'b0); step(); chk("j_3010b", pc, 32'h3010);
    drive(3'd1, 26'h000FFFC, 1'b0, 32'd0, 1'b0);
    step(); chk("br_nt_pc", pc, 32'h3014);

    // JAL then RET
    drive(3'd2, 26'h0000C08, 1'b0, 32'd0, 1'b0); step(); chk("j_3020", pc, 32'h3020);
    drive(3'd3, 26'h0000C40, 1'b0, 32'd0, 1'b0); step();
    chk("jal_pc", pc, 32'h3100);
    chk("jal_empty", 32'(ras_empty), 32'd0);
    drive(3'd6, 26'd0, 1'b0, 32'hDEAD0000, 1'b0);
    #1 chk("ret_npc", npc, 32'h3024);
    step();
    chk("ret_pc", pc, 32'h3024);
    chk("ret_empty", 32'(ras_empty), 32'd1);
    chk("ret_nomiss", 32'(ras_miss), 32'd0);

    // Five pushes into a 4-deep RAS
    drive(3'd3, 26'h0000C40, 1'b0, 32'd0, 1'b0); step(); chk("ov_p1", pc, 32'h3100);
    drive(3'd3, 26'h0000C80, 1'b0, 32'd0, 1'b0); step(); chk("ov_p2", pc, 32'h3200);
    drive(3'd3, 26'h0000CC0, 1'b0, 32'd0, 1'b0); step(); chk("ov_p3", pc, 32'h3300);
    chk("ov_notfull", 32'(ras_full), 32'd0);
    drive(3'd3, 26'h0000D00, 1'b0, 32'd0, 1'b0); step(); chk("ov_p4", pc, 32'h3400);
    chk("ov_full4", 32'(ras_full), 32'd1);
    drive(3'd3, 26'h0000D40, 1'b0, 32'd0, 1'b0); step(); chk("ov_p5", pc, 32'h3500);
    chk("ov_full5", 32'(ras_full), 32'd1);

    drive(3'd6, 26'd0, 1'b0, 32'h00003500, 1'b0);
    #1 chk("pop1_npc", npc, 32'h3404);
    step(); chk("pop1_pc", pc, 32'h3404);
    chk("pop1_full", 32'(ras_full), 32'd0);
    step(); chk("pop2_pc", pc, 32'h3304);
    step(); chk("pop3_pc", pc, 32'h3204);
    step(); chk("pop4_pc", pc, 32'h3104);
    chk("pop4_empty", 32'(ras_empty), 32'd1);
    chk("pop4_nomiss", 32'(ras_miss), 32'd0);
    #1 chk("miss_npc", npc, 32'h3500);
    step();
    chk("miss_pc", pc, 32'h3500);
    chk("miss_pulse", 32'(ras_miss), 32'd1);
    drive(3'd0, 26'd0, 1'b0, 32'd0, 1'b0);
    step();
    chk("miss_clear", 32'(ras_miss), 32'd0);
    chk("miss_seq", pc, 32'h3504);

    // JAL held by stall for two edges
    drive(3'd3, 26'h0000E00, 1'b0, 32'd0, 1'b1);
    #1 chk("st_npc", npc, 32'h3800);
    step(); chk("st1_pc", pc, 32'h3504); chk("st1_empty", 32'(ras_empty), 32'd1);
    step(); chk("st2_pc", pc, 32'h3504); chk("st2_empty", 32'(ras_empty), 32'd1);
    stall = 1'b0;
    step(); chk("st_rel_pc", pc, 32'h3800); chk("st_rel_empty", 32'(ras_empty), 32'd0);
    drive(3'd6, 26'd0, 1'b0, 32'd0, 1'b0);
    step(); chk("st_ret_pc", pc, 32'h3508); chk("st_ret_empty", 32'(ras_empty), 32'd1);

    // JR to a misaligned target
    drive(3'd4, 26'd0, 1'b0, 32'h00003002, 1'b0);
    step();
`ifdef PC_ALIGN_CHECK_EN
    chk("jr_pc", pc, 32'h4180);
    chk("jr_mis", 32'(pc_misalign), 32'd1);
    drive(3'd0, 26'd0, 1'b0, 32'd0, 1'b0);
    step();
    chk("jr_mis_clr", 32'(pc_misalign), 32'd0);
`else
    chk("jr_pc", pc, 32'h3002);
    drive(3'd0, 26'd0, 1'b0, 32'd0, 1'b0);
    #1 chk("jr_npc", npc, 32'h3006);
    step();
    chk("jr_seq", pc, 32'h3006);
`endif

    // Asynchronous reset mid-sequence clears RAS while stalled
    drive(3'd3, 26'h0000C40, 1'b0, 32'd0, 1'b0);
    step(); chk("mr_jal_pc", pc, 32'h3100); chk("mr_jal_empty", 32'(ras_empty), 32'd0);
    stall = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("mr_pc", pc, 32'h3000);
    chk("mr_empty", 32'(ras_empty), 32'd1);
    drive(3'd0, 26'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(); chk("mr_seq", pc, 32'h3004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
